// File: rtl/uart_tx_arb_if.sv
// Byte-producer and transmitter signals of the shared-UART arbiter.
// Producer handshake: req[i] is raised with req_data/req_last stable and held until a one-cycle ack[i]; dropping req earlier withdraws the byte.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   sent;
  logic               trmt;
  logic [7:0]         tx_data;
  logic               tx_done;

  modport master (
    output req, req_data, req_last, tx_done,
    input  ack, sent, trmt, tx_data
  );

  modport slave (
    input  req, req_data, req_last, tx_done,
    output ack, sent, trmt, tx_data
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers,
// with multi-byte frame locking and a watchdog on a stalled transmitter.
module uart_tx_arb #(
  parameter int N_REQ      = 4,
  parameter int TMO_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_arb_if.slave             bus,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     tmo_err,
  output logic [2:0]               state_dbg,
  output logic [$clog2(N_REQ)-1:0] rr_ptr_dbg
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);
  localparam logic [GW-1:0] LAST_ID  = GW'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, BUSY, LOCK_WAIT} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d, sent_q, sent_d;
  logic             trmt_q, trmt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [GW-1:0]    gnt_q, gnt_d, rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             busy_q;
  logic             win_vld;
  logic [GW-1:0]    win_id;
  logic [GW-1:0]    gnt_nxt;
  logic             tmo_hit;

  // First requester at or after rr_q, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && bus.req[(int'(rr_q) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win_id  = GW'((int'(rr_q) + i) % N_REQ);
      end
    end
  end

  assign gnt_nxt = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
  assign tmo_hit = (cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    sent_d    = '0;
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d        = LAUNCH;
          gnt_d          = win_id;
          tx_data_d      = bus.req_data[8*win_id +: 8];
          lock_d         = ~bus.req_last[win_id];
          ack_d[win_id]  = 1'b1;
          trmt_d         = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = ARM;
        cnt_d   = '0;
      end
      ARM: begin
        cnt_d = cnt_q + 1'b1;
        if (tmo_hit) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          rr_d    = gnt_nxt;
        end else if (!bus.tx_done) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A completing byte wins over a watchdog expiring on the same cycle.
        if (bus.tx_done) begin
          sent_d[gnt_q] = 1'b1;
          if (lock_q) begin
            state_d = LOCK_WAIT;
          end else begin
            state_d = IDLE;
            rr_d    = gnt_nxt;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          rr_d    = gnt_nxt;
        end
      end
      LOCK_WAIT: begin
        if (bus.req[gnt_q]) begin
          state_d       = LAUNCH;
          tx_data_d     = bus.req_data[8*gnt_q +: 8];
          lock_d        = ~bus.req_last[gnt_q];
          ack_d[gnt_q]  = 1'b1;
          trmt_d        = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      sent_q    <= '0;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      gnt_q     <= '0;
      rr_q      <= '0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      sent_q    <= sent_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.ack     = ack_q;
  assign bus.sent    = sent_q;
  assign bus.trmt    = trmt_q;
  assign bus.tx_data = tx_data_q;
  assign busy        = busy_q;
  assign gnt_id      = gnt_q;
  assign tmo_err     = tmo_q;
  assign state_dbg   = state_q;
  assign rr_ptr_dbg  = rr_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a behavioural transmitter plus a grant/byte scoreboard.
module tb_uart_tx_arb;
  localparam int N_REQ = 4;
  localparam int TMO   = 100;
  localparam int W     = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, tmo_err;
  logic [1:0] gnt_id, rr_ptr_dbg;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N_REQ)) bus();

  uart_tx_arb #(.N_REQ(N_REQ), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .gnt_id(gnt_id),
    .tmo_err(tmo_err), .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  // Transmitter model: done flag sticky high, cleared clear_dly cycles after trmt,
  // set again busy_len cycles later (busy_len 0 = stalled forever).
  int clear_dly = 0;
  int busy_len  = 5;
  int clr_cnt   = 0;
  int done_cnt  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_done = 1'b1;
      clr_cnt     = 0;
      done_cnt    = 0;
    end else if (bus.trmt) begin
      done_cnt = busy_len;
      clr_cnt  = clear_dly;
      if (clear_dly == 0) bus.tx_done = 1'b0;
    end else if (clr_cnt > 0) begin
      clr_cnt--;
      if (clr_cnt == 0) bus.tx_done = 1'b0;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus.tx_done = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, got time %0t want < 200000", $time);
    $fatal(1);
  end

  task automatic wait_trmt(input int max, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= max && !ok; i++) begin
      @(negedge clk);
      if (bus.trmt) begin
        ok = 1'b1;
        n  = i;
      end
    end
  endtask

  task automatic wait_sent(input int max, output bit ok, output int n, output logic [3:0] s);
    ok = 1'b0;
    n  = 0;
    s  = '0;
    for (int i = 1; i <= max && !ok; i++) begin
      @(negedge clk);
      if (bus.sent != 0) begin
        ok = 1'b1;
        n  = i;
        s  = bus.sent;
      end
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({bus.ack, bus.sent, bus.trmt, busy, tmo_err} !== 11'd0) $display("FAIL reset_ctrl: got %b want 0", {bus.ack, bus.sent, bus.trmt, busy, tmo_err}); else n_pass++;
    n_chk++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else n_pass++;
    n_chk++; if (gnt_id !== 2'd0 || rr_ptr_dbg !== 2'd0) $display("FAIL reset_ptr: got gnt %0d rr %0d want 0 0", gnt_id, rr_ptr_dbg); else n_pass++;
    n_chk++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int n; logic [3:0] s; logic [W-1:0] e;
    busy_len = 5; clear_dly = 0;
    @(negedge clk);
    bus.req_data[23:16] = 8'hA5;
    bus.req_last = 4'b0100;
    bus.req = 4'b0100;
    exp_q.push_back({2'd2, 8'hA5});
    wait_trmt(10, ok, n);
    n_chk++; if (!ok || n != 1) $display("FAIL single_latency: got %0d cycles want 1", n); else n_pass++;
    if (ok) begin
      e = exp_q.pop_front();
      n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL single_grant: got %h want %h", {gnt_id, bus.tx_data}, e); else n_pass++;
      n_chk++; if (bus.ack !== (4'b1 << e[9:8])) $display("FAIL single_ack: got %b want %b", bus.ack, 4'b1 << e[9:8]); else n_pass++;
    end
    bus.req = '0;
    wait_sent(20, ok, n, s);
    n_chk++; if (!ok || n != 6 || s !== 4'b0100) $display("FAIL single_sent: got n %0d sent %b want 6 0100", n, s); else n_pass++;
    n_chk++; if (busy !== 1'b0 || state_dbg !== 3'd0 || rr_ptr_dbg !== 2'd3) $display("FAIL single_after: got busy %b st %0d rr %0d want 0 0 3", busy, state_dbg, rr_ptr_dbg); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok; int n; int rr; logic [W-1:0] e; logic [1:0] id;
    do_reset();
    rr = 0;
    for (int k = 0; k < 5; k++) begin
      id = 2'(rr);
      exp_q.push_back({id, 8'h10 + {6'd0, id}});
      rr = (rr + 1) % N_REQ;
    end
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_last = 4'hF;
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_trmt(40, ok, n);
      n_chk++; if (!ok) $display("FAIL rr_trmt_%0d: got no trmt want trmt within 40", k); else n_pass++;
      if (ok) begin
        e = exp_q.pop_front();
        n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL rr_grant_%0d: got %h want %h", k, {gnt_id, bus.tx_data}, e); else n_pass++;
        n_chk++; if (bus.ack !== (4'b1 << e[9:8])) $display("FAIL rr_ack_%0d: got %b want %b", k, bus.ack, 4'b1 << e[9:8]); else n_pass++;
      end
    end
    bus.req = '0;
    wait_idle(40, ok);
    n_chk++; if (!ok) $display("FAIL rr_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_frame_lock();
    bit ok; int n; logic [W-1:0] e;
    exp_q.push_back({2'd1, 8'h01});
    exp_q.push_back({2'd1, 8'h02});
    exp_q.push_back({2'd1, 8'h03});
    exp_q.push_back({2'd3, 8'h33});
    exp_q.push_back({2'd0, 8'h30});
    @(negedge clk);
    bus.req_data = {8'h33, 8'h00, 8'h01, 8'h30};
    bus.req_last = 4'b1001;
    bus.req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      wait_trmt(40, ok, n);
      n_chk++; if (!ok) $display("FAIL lock_trmt_%0d: got no trmt want trmt within 40", k); else n_pass++;
      if (ok) begin
        e = exp_q.pop_front();
        n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL lock_grant_%0d: got %h want %h", k, {gnt_id, bus.tx_data}, e); else n_pass++;
      end
      case (k)
        0: begin bus.req_data[15:8] = 8'h02; bus.req = 4'b1011; end
        1: begin bus.req_data[15:8] = 8'h03; bus.req_last[1] = 1'b1; end
        2: bus.req[1] = 1'b0;
        3: bus.req[3] = 1'b0;
        default: bus.req[0] = 1'b0;
      endcase
    end
    wait_idle(40, ok);
    n_chk++; if (!ok) $display("FAIL lock_idle: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok; bit saw_sent; int n; logic [3:0] s; logic [W-1:0] e;
    busy_len = 0;
    @(negedge clk);
    bus.req_data[23:16] = 8'h5A;
    bus.req_last = 4'b0100;
    bus.req = 4'b0100;
    exp_q.push_back({2'd2, 8'h5A});
    wait_trmt(10, ok, n);
    if (ok) begin
      e = exp_q.pop_front();
      n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL tmo_grant: got %h want %h", {gnt_id, bus.tx_data}, e); else n_pass++;
    end
    bus.req = '0;
    saw_sent = 1'b0;
    n = 0;
    for (int i = 1; i <= 200 && n == 0; i++) begin
      @(negedge clk);
      if (bus.sent != 0) saw_sent = 1'b1;
      if (tmo_err === 1'b1) n = i;
    end
    n_chk++; if (n != TMO + 1) $display("FAIL tmo_when: got %0d cycles want %0d", n, TMO + 1); else n_pass++;
    n_chk++; if (saw_sent) $display("FAIL tmo_no_sent: got sent pulse want none"); else n_pass++;
    n_chk++; if (busy !== 1'b0 || state_dbg !== 3'd0) $display("FAIL tmo_idle: got busy %b st %0d want 0 0", busy, state_dbg); else n_pass++;
    busy_len = 5;
    @(negedge clk);
    bus.req_data[7:0] = 8'h77;
    bus.req_last = 4'b0001;
    bus.req = 4'b0001;
    exp_q.push_back({2'd0, 8'h77});
    wait_trmt(10, ok, n);
    if (ok) begin
      e = exp_q.pop_front();
      n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL tmo_next_grant: got %h want %h", {gnt_id, bus.tx_data}, e); else n_pass++;
    end
    bus.req = '0;
    wait_sent(20, ok, n, s);
    n_chk++; if (!ok || s !== 4'b0001 || tmo_err !== 1'b1) $display("FAIL tmo_next_sent: got sent %b tmo %b want 0001 1", s, tmo_err); else n_pass++;
  endtask

  task automatic test_reset_mid_lock();
    bit ok; int n; logic [3:0] s; logic [W-1:0] e;
    busy_len = 20;
    @(negedge clk);
    bus.req_data[15:8] = 8'h41;
    bus.req_last = 4'b0000;
    bus.req = 4'b0010;
    exp_q.push_back({2'd1, 8'h41});
    wait_trmt(10, ok, n);
    if (ok) begin
      e = exp_q.pop_front();
      n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL mid_grant: got %h want %h", {gnt_id, bus.tx_data}, e); else n_pass++;
    end
    bus.req = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if ({bus.ack, bus.sent, bus.trmt, busy, tmo_err} !== 11'd0) $display("FAIL mid_reset_ctrl: got %b want 0", {bus.ack, bus.sent, bus.trmt, busy, tmo_err}); else n_pass++;
    n_chk++; if (bus.tx_data !== 8'h00 || gnt_id !== 2'd0 || rr_ptr_dbg !== 2'd0 || state_dbg !== 3'd0) $display("FAIL mid_reset_regs: got data %h gnt %0d rr %0d st %0d want 00 0 0 0", bus.tx_data, gnt_id, rr_ptr_dbg, state_dbg); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    busy_len = 5;
    @(negedge clk);
    bus.req_data[31:24] = 8'h63;
    bus.req_last = 4'b1000;
    bus.req = 4'b1000;
    exp_q.push_back({2'd3, 8'h63});
    wait_trmt(10, ok, n);
    n_chk++; if (!ok) $display("FAIL mid_regrant: got no trmt want trmt within 10"); else n_pass++;
    if (ok) begin
      e = exp_q.pop_front();
      n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL mid_regrant_id: got %h want %h", {gnt_id, bus.tx_data}, e); else n_pass++;
    end
    bus.req = '0;
    wait_sent(30, ok, n, s);
    n_chk++; if (!ok || s !== 4'b1000) $display("FAIL mid_sent: got %b want 1000", s); else n_pass++;
  endtask

  task automatic test_stale_done();
    bit ok; bit saw_low; int n; logic [3:0] s; logic [W-1:0] e;
    clear_dly = 3;
    busy_len = 4;
    @(negedge clk);
    bus.req_data[23:16] = 8'hC3;
    bus.req_last = 4'b0100;
    bus.req = 4'b0100;
    exp_q.push_back({2'd2, 8'hC3});
    wait_trmt(10, ok, n);
    if (ok) begin
      e = exp_q.pop_front();
      n_chk++; if ({gnt_id, bus.tx_data} !== e) $display("FAIL stale_grant: got %h want %h", {gnt_id, bus.tx_data}, e); else n_pass++;
    end
    bus.req = '0;
    saw_low = 1'b0;
    n = 0;
    s = '0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      @(negedge clk);
      #1;
      if (bus.sent != 0) begin
        n = i;
        s = bus.sent;
        n_chk++; if (!saw_low) $display("FAIL stale_early_sent: got sent %b before tx_done low want none", bus.sent); else n_pass++;
      end
      if (bus.tx_done === 1'b0) saw_low = 1'b1;
    end
    n_chk++; if (n != 8 || s !== 4'b0100) $display("FAIL stale_sent: got n %0d sent %b want 8 0100", n, s); else n_pass++;
    clear_dly = 0;
    busy_len = 5;
  endtask

  initial begin
    bus.req = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_frame_lock();
    test_timeout();
    test_reset_mid_lock();
    test_stale_done();
    n_chk++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin scheduler that shares one UART transmitter among N_REQ byte producers (command parser, telemetry, debug echo, …).
- Accepts one byte per grant, pulses trmt/tx_data into the transmitter and tracks tx_done for completion.
- Supports multi-byte frame locking: a requester keeps the transmitter until it sends a byte flagged last.
- Watchdog timeout recovers from a stalled transmitter.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TMO_CYCLES, 65535, max cycles in ARM+BUSY before timeout; counter width $clog2(TMO_CYCLES+1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester byte-valid; held high with data until ack.
- req_data  input  8*N_REQ  byte i at [8i+7:8i].
- req_last  input  N_REQ  byte closes a frame (releases lock).
- ack  output  N_REQ  one-cycle pulse: byte captured.
- sent  output  N_REQ  one-cycle pulse: byte fully transmitted.
- trmt  output  1  one-cycle start pulse to transmitter.
- tx_data  output  8  byte to transmitter, stable from trmt until next capture.
- tx_done  input  1  transmitter done flag (sticky high, cleared by transmitter after trmt).
- busy  output  1  high in any state except IDLE.
- gnt_id  output  $clog2(N_REQ)  index of current/last granted requester.
- tmo_err  output  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset values:
  - ack, sent, trmt, busy, tmo_err = 0; tx_data = 0x00; gnt_id = 0.
  - rr pointer = 0; lock = 0; state = IDLE.
- All outputs are registered.
- States: IDLE, LAUNCH, ARM, BUSY, LOCK_WAIT.
- IDLE:
  - Selects the first requester with req=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - On the edge that sees a winner: capture byte into tx_data, gnt_id = winner, lock = ~req_last[winner]; next state LAUNCH.
- LAUNCH:
  - ack[gnt_id] = 1 and trmt = 1 for exactly this one cycle.
  - Next state ARM.
  - Latency: req sampled at edge E produces ack/trmt in the cycle after E.
- ARM:
  - Waits for tx_done == 0, i.e. the transmitter has accepted the start and cleared its stale done flag.
  - Then BUSY.
- BUSY:
  - Waits for tx_done == 1; on that edge sent[gnt_id] pulses one cycle.
  - Next state LOCK_WAIT if lock = 1, else IDLE with rr_ptr = gnt_id+1 (wraps to 0 past N_REQ-1).
- LOCK_WAIT:
  - Only req[gnt_id] is considered; all other reqs are ignored, however long they wait.
  - When req[gnt_id] = 1: capture byte, lock = ~req_last[gnt_id]; next state LAUNCH. rr_ptr is unchanged.
- Fairness: after a frame or single byte from requester k, requester k is lowest priority in the next IDLE arbitration.
- Simultaneous requests: resolved strictly by rr order in the same cycle; non-winners see no ack and must keep req high.
- req dropped before ack: no byte captured; no effect.
- Watchdog:
  - Counter clears on entering ARM and increments each cycle in ARM or BUSY.
  - Reaching TMO_CYCLES: set tmo_err, clear lock, no sent pulse, rr_ptr = gnt_id+1, go IDLE.
- tx_done already 0 on entering ARM: ARM exits after one cycle.
- Reset mid-operation: everything returns to reset values immediately; a partially sent byte is abandoned and the lock is dropped.
- gnt_id holds its value in IDLE.

Test Plan:
- Single request: req[2]=1, data 0xA5, last=1.
  - Expect ack[2] and trmt together one cycle after the sampling edge, tx_data=0xA5, sent[2] when tx_done rises.
  - Then IDLE, busy=0, rr_ptr=3.
- All four requesting continuously, last=1, byte i = 0x10+i.
  - Grant order 0,1,2,3,0; transmitted bytes 0x10,0x11,0x12,0x13,0x10.
  - No requester acked twice before the others are served.
- Frame lock: req1 sends 0x01,0x02,0x03 with last only on 0x03 while req0 and req3 are held high.
  - All three req1 bytes are sent back-to-back; next grant is req3, then req0.
- Timeout: tx_done held at 0 after trmt with TMO_CYCLES=100.
  - At cycle 100 tmo_err=1, no sent pulse, FSM back in IDLE; next request is still served.
- Reset during BUSY of a locked frame.
  - All outputs go to reset values; after reset, another requester is granted (lock dropped) and rr_ptr=0.
- Stale tx_done=1 at LAUNCH, cleared 3 cycles later.
  - sent is not pulsed until tx_done has gone low then high again.
